axi_burst_pattern_master: RTL

Parametrised AXI4 full-protocol burst master for bring-up and self-test of memory-mapped slaves in the capture path. On an init pulse it writes an incrementing pattern across a configurable number of INCR bursts, then reads the same region back and compares every beat. Results are reported as done, error and mismatch-count outputs. It generalises the single-mode template master with programmable data width, burst length, burst count, run mode, seed and error counting.

---
 rtl/axi_burst_pattern_master.sv | 283 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_pattern_master.sv
// AXI4 burst pattern master: writes SEED+k across NUM_BURSTS INCR bursts, then reads
// the region back and counts mismatching or erroneous beats.
module axi_burst_pattern_master #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_BURST_LEN  = 16,
  parameter int unsigned                   C_NUM_BURSTS       = 4,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_TARGET_BASE_ADDR = 32'h4000_0000
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            INIT_AXI_TXN,
  input  logic [1:0]                      MODE,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   SEED,
  output logic                            TXN_DONE,
  output logic                            ERROR,
  output logic [15:0]                     ERR_COUNT,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam int unsigned ADDR_W      = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW          = C_M_AXI_DATA_WIDTH;
  localparam int unsigned BL          = C_M_AXI_BURST_LEN;
  localparam int unsigned NB          = C_NUM_BURSTS;
  localparam int unsigned STRB_W      = DW / 8;
  localparam int unsigned BURST_BYTES = BL * STRB_W;
  localparam int unsigned BEAT_W      = $clog2(BL + 1);
  localparam int unsigned BURST_W     = $clog2(NB + 1);

  localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BL - 1);
  localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NB - 1);
  localparam logic [2:0]         AXI_SIZE   = 3'($clog2(STRB_W));
  localparam logic               ONE_BEAT   = (BL == 1);

  typedef enum logic [2:0] {S_IDLE, S_WR_BURST, S_WR_RESP, S_RD_BURST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                init_q, init_d, start_q, start_d;
  logic                wr_only_q, wr_only_d;
  logic [DW-1:0]       seed_q, seed_d, pat_q, pat_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, wlast_q, wlast_d;
  logic                bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic                txn_done_q, txn_done_d, error_q, error_d;
  logic [15:0]         err_count_q, err_count_d;
  logic                err_inc_c;

  logic                aw_fire_c, w_fire_c, b_fire_c, ar_fire_c, r_fire_c, rd_last_c;
  logic [ADDR_W-1:0]   next_addr_c;

  assign aw_fire_c   = awvalid_q & M_AXI_AWREADY;
  assign w_fire_c    = wvalid_q & M_AXI_WREADY;
  assign b_fire_c    = bready_q & M_AXI_BVALID;
  assign ar_fire_c   = arvalid_q & M_AXI_ARREADY;
  assign r_fire_c    = rready_q & M_AXI_RVALID;
  assign rd_last_c   = (beat_q == LAST_BEAT);
  assign next_addr_c = addr_q + ADDR_W'(BURST_BYTES);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    init_d      = INIT_AXI_TXN;
    start_d     = INIT_AXI_TXN & ~init_q;
    wr_only_d   = wr_only_q;
    seed_d      = seed_q;
    pat_d       = pat_q;
    beat_d      = beat_q;
    burst_d     = burst_q;
    addr_d      = addr_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    wlast_d     = wlast_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    txn_done_d  = txn_done_q;
    error_d     = error_q;
    err_count_d = err_count_q;
    err_inc_c   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_q) begin
          seed_d      = SEED;
          pat_d       = SEED;
          wr_only_d   = (MODE == 2'b01);
          txn_done_d  = 1'b0;
          error_d     = 1'b0;
          err_count_d = '0;
          burst_d     = '0;
          beat_d      = '0;
          addr_d      = C_TARGET_BASE_ADDR;
          if (MODE == 2'b10) begin
            state_d   = S_RD_BURST;
            arvalid_d = 1'b1;
            araddr_d  = C_TARGET_BASE_ADDR;
            rready_d  = 1'b1;
          end else begin
            state_d   = S_WR_BURST;
            awvalid_d = 1'b1;
            awaddr_d  = C_TARGET_BASE_ADDR;
            wvalid_d  = 1'b1;
            wlast_d   = ONE_BEAT;
          end
        end
      end

      S_WR_BURST: begin
        if (aw_fire_c) awvalid_d = 1'b0;
        if (w_fire_c) begin
          pat_d = pat_q + DW'(1);
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            wlast_d = ((beat_q + BEAT_W'(1)) == LAST_BEAT);
          end
        end
        // A dropped VALID means that channel already completed this burst
        if ((~awvalid_q | aw_fire_c) & (~wvalid_q | (w_fire_c & wlast_q))) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end
      end

      S_WR_RESP: begin
        if (b_fire_c) begin
          bready_d  = 1'b0;
          beat_d    = '0;
          err_inc_c = (M_AXI_BRESP != 2'b00);
          if (burst_q != LAST_BURST) begin
            state_d   = S_WR_BURST;
            burst_d   = burst_q + BURST_W'(1);
            addr_d    = next_addr_c;
            awaddr_d  = next_addr_c;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            wlast_d   = ONE_BEAT;
          end else if (wr_only_q) begin
            state_d    = S_DONE;
            txn_done_d = 1'b1;
          end else begin
            state_d   = S_RD_BURST;
            burst_d   = '0;
            pat_d     = seed_q;
            addr_d    = C_TARGET_BASE_ADDR;
            araddr_d  = C_TARGET_BASE_ADDR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end

      S_RD_BURST: begin
        if (ar_fire_c) arvalid_d = 1'b0;
        if (r_fire_c) begin
          pat_d     = pat_q + DW'(1);
          err_inc_c = (M_AXI_RDATA != pat_q) || (M_AXI_RRESP != 2'b00) ||
                      (M_AXI_RLAST != rd_last_c);
          // Burst ends on the beat count so a missing RLAST cannot stall the run
          if (rd_last_c) begin
            beat_d = '0;
            if (burst_q == LAST_BURST) begin
              state_d    = S_DONE;
              rready_d   = 1'b0;
              txn_done_d = 1'b1;
            end else begin
              burst_d   = burst_q + BURST_W'(1);
              addr_d    = next_addr_c;
              araddr_d  = next_addr_c;
              arvalid_d = 1'b1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (err_inc_c) begin
      error_d = 1'b1;
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      init_q      <= 1'b0;
      start_q     <= 1'b0;
      wr_only_q   <= 1'b0;
      seed_q      <= '0;
      pat_q       <= '0;
      beat_q      <= '0;
      burst_q     <= '0;
      addr_q      <= '0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      txn_done_q  <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      start_q     <= start_d;
      wr_only_q   <= wr_only_d;
      seed_q      <= seed_d;
      pat_q       <= pat_d;
      beat_q      <= beat_d;
      burst_q     <= burst_d;
      addr_q      <= addr_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      wlast_q     <= wlast_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      txn_done_q  <= txn_done_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  assign TXN_DONE      = txn_done_q;
  assign ERROR         = error_q;
  assign ERR_COUNT     = err_count_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'(BL - 1);
  assign M_AXI_AWSIZE  = AXI_SIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = pat_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARLEN   = 8'(BL - 1);
  assign M_AXI_ARSIZE  = AXI_SIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
